add64_seq_ctrl: RTL
===================

# add64_seq_ctrl

Multi-precision add/subtract sequencer that reuses one 16-bit carry-lookahead adder slice over several cycles to produce a wide result. It captures two wide operands on a start strobe and feeds them to the slice one 16-bit word per cycle, least significant word first. The carry between words is held in a register, and the block pulses `done` when the full sum is ready. It sits between a register-file/bus master and the shared 16-bit adder datapath, and trades latency for area against a fully parallel wide adder.

## Interface

Parameters:
- `NWORDS`, default 4: number of 16-bit words. Operand width is W = 16*NWORDS. Legal range is 1..8.

Ports:
- `clk` input 1: single clock. Everything is rising-edge triggered.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request strobe. Sampled only in IDLE.
- `sub` input 1: 0 = a+b+ci; 1 = a-b (computed as a + ~b + 1).
- `ci` input 1: carry-in for add. Ignored when `sub`=1.
- `a` input W: operand A. Captured on an accepted start.
- `b` input W: operand B. Captured on an accepted start.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse. Result outputs are valid in that cycle.
- `sum` output W: result register.
- `co` output 1: carry-out of the MS word. For `sub`=1, co=1 means no borrow (a >= b unsigned).
- `ovf` output 1: signed two's-complement overflow of the full W-bit operation.

## Operation

- Three states: IDLE, RUN, DONE. The word index `idx` has width clog2(NWORDS), minimum 1 bit.
- IDLE:
  - On `start`=1, latch `a` into opA and latch `b` or `~b` (per `sub`) into opB.
  - Set carry reg = `sub` ? 1 : `ci`, idx=0, and go to RUN.
  - While `start`=0, stay in IDLE.
- RUN, each cycle:
  - The slice computes opA[16*idx+:16] + opB[16*idx+:16] + carry reg.
  - The result word is written to sum[16*idx+:16] and the slice carry-out goes to the carry reg.
  - If idx == NWORDS-1: write `co` from the slice carry-out, write `ovf` = carry into bit W-1 XOR carry out of bit W-1, then go to DONE. Otherwise idx increments.
- DONE:
  - `done`=1 for exactly this cycle. Unconditionally return to IDLE on the next edge.
- `start` is ignored in RUN and DONE. There is no queueing; the requester must wait for `done`.
- Output validity:
  - `sum`, `co` and `ovf` are meaningful in the `done` cycle.
  - They hold their values through IDLE until the next accepted start.
  - During RUN, `sum` is partially updated and must not be consumed.
- The operand registers isolate the block from changes on `a`, `b`, `sub` and `ci` after acceptance.
- Arithmetic is modulo 2^W. No saturation.

## Timing

- Reset (async, any state):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `sum`=0, `co`=0, `ovf`=0, idx=0, carry reg=0.
  - Operand registers are cleared.
- Reset during RUN aborts the operation. No `done` is produced.
- After `rst` deasserts, the first start is accepted on the first rising edge at which `start`=1.
- Latency:
  - Start is sampled on edge E0. RUN covers edges E1..E_NWORDS.
  - `done` is high in the cycle after E_NWORDS, i.e. NWORDS+1 edges after E0 inclusive.
  - `busy` is high from after E0 through the `done` cycle.
- Throughput: one operation per NWORDS+2 cycles (start-to-start minimum).
- Combinational path: one 16-bit slice plus the word mux per cycle. No wide carry chain.
- All outputs are registered.

## Test plan

- Word-boundary carry, default NWORDS=4:
  - Stimulus: a=0x0000_0000_0000_FFFF, b=0x1, ci=0, sub=0.
  - Response: sum=0x0000_0000_0001_0000, co=0, ovf=0. `done` pulses exactly 5 edges after the start edge, and `busy` is high for 5 cycles.
- Full carry ripple across all words:
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1.
  - Response: sum=0, co=1, ovf=0.
- Signed overflow:
  - Stimulus: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1.
  - Response: sum=0x8000_0000_0000_0000, co=0, ovf=1.
- Subtract with borrow:
  - Stimulus: a=0x5, b=0x7, sub=1, ci=1. `ci` must be ignored.
  - Response: sum=0xFFFF_FFFF_FFFF_FFFE, co=0, ovf=0.
- Protocol robustness:
  - Stimulus: hold `start` high continuously and change `a`/`b` every cycle during RUN. Separately, assert `rst` in the 2nd RUN cycle.
  - Response: the first result reflects the operands captured at acceptance, and the next start is accepted only in IDLE after `done`. The reset run gives no `done` and all outputs 0.
- Parameter NWORDS=1:
  - Stimulus: a=0x0C28, b=0x4CBA, ci=0.
  - Response: sum=0x58E2, co=0, ovf=0, with `done` 2 edges after start.
  - Also randomize 1000 vectors per NWORDS in {1,2,4} and compare against a behavioral W-bit reference.

Source files
------------

// File: rtl/add64_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 16-bit carry-lookahead slice is
// stepped over NWORDS words, LS word first, with the inter-word carry registered.
module add64_seq_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 ci,
  input  logic [16*NWORDS-1:0] a,
  input  logic [16*NWORDS-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [16*NWORDS-1:0] sum,
  output logic                 co,
  output logic                 ovf
);
  // state | meaning
  // IDLE  | waiting for start, last result held
  // RUN   | one word per cycle through the slice
  // DONE  | result valid, done pulse
  localparam int W  = 16 * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  op_a, op_b;
  logic [IW-1:0] idx;
  logic          carry;
  logic [15:0]   slice_a, slice_b, slice_s;
  logic          slice_c15, slice_co;
  logic          last;

  // Two-level lookahead: 4-bit groups, then group generate/propagate.
  // Returns {carry into bit 15, carry out, sum}.
  function automatic logic [17:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin);
    logic [15:0] g, p;
    logic [16:0] c;
    logic [3:0]  gg, gp;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    c     = '0;
    c[0]  = cin;
    c[4]  = gg[0] | (gp[0] & cin);
    c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    return {c[15], c[16], p ^ c[15:0]};
  endfunction

  always_comb begin
    slice_a = op_a[16*idx +: 16];
    slice_b = op_b[16*idx +: 16];
    {slice_c15, slice_co, slice_s} = cla16(slice_a, slice_b, carry);
    last = (idx == LAST);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub | ci;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[16*idx +: 16] <= slice_s;
          carry             <= slice_co;
          if (last) begin
            co  <= slice_co;
            ovf <= slice_c15 ^ slice_co;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
